// File: rtl/usb_fifo_responder.sv
// Device-side model of an FT245-style USB FIFO: RX byte FIFO presented over rd_n/rxf_n,
// and wr_n/txe_n write capture decoded from 4-byte tagged frames into a 16-bit panel value.
module usb_fifo_responder #(
   parameter int RX_DEPTH        = 8,
   parameter int TXE_BUSY_CYCLES = 2
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [7:0]                host_data,
   input  logic                      host_valid,
   output logic                      host_ready,
   input  logic                      rd_n,
   input  logic                      wr_n,
   input  logic [7:0]                data_in,
   output logic [7:0]                data_out,
   output logic                      data_out_enable,
   output logic                      rxf_n,
   output logic                      txe_n,
   output logic [15:0]               panel_value,
   output logic                      panel_valid,
   output logic                      frame_error,
   output logic                      rd_err,
   output logic                      wr_err,
   output logic [$clog2(RX_DEPTH):0] rx_count
);

   localparam int AW = $clog2(RX_DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = $clog2(TXE_BUSY_CYCLES + 1);

   typedef enum logic [1:0] {EXP1, EXP2, EXP3, EXP4} state_t;

   // ---------------- RX FIFO and read handshake ----------------
   logic [7:0]    r_mem [RX_DEPTH];
   logic [AW-1:0] r_wptr, r_rptr;
   logic [CW-1:0] r_count, w_count_next;
   logic          r_rd_prev, r_rd_active, r_rxf_n, r_doe, r_rd_err;
   logic [7:0]    r_dout;
   logic          w_push, w_pop, w_rd_fall, w_rd_rise;

   assign host_ready = (r_count < CW'(RX_DEPTH));
   assign w_push     = host_valid & host_ready;
   assign w_rd_fall  = r_rd_prev & ~rd_n;
   assign w_rd_rise  = ~r_rd_prev & rd_n;
   // Only a read that started on a non-empty FIFO consumes the head.
   assign w_pop      = w_rd_rise & r_rd_active;

   always_comb begin
      w_count_next = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_next = r_count + CW'(1);
         2'b01:   w_count_next = r_count - CW'(1);
         default: w_count_next = r_count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wptr] <= host_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_count     <= '0;
         r_rd_prev   <= 1'b1;
         r_rd_active <= 1'b0;
         r_rxf_n     <= 1'b1;
         r_doe       <= 1'b0;
         r_dout      <= 8'h00;
         r_rd_err    <= 1'b0;
      end else begin
         r_rd_prev <= rd_n;
         r_rd_err  <= 1'b0;
         if (w_push) r_wptr <= r_wptr + AW'(1);
         if (w_pop)  r_rptr <= r_rptr + AW'(1);
         r_count   <= w_count_next;
         // rxf_n also idles high for one cycle after every read strobe.
         r_rxf_n   <= (w_count_next == '0) | w_rd_rise;
         if (w_rd_fall) begin
            if (r_count != '0) begin
               r_dout      <= r_mem[r_rptr];
               r_doe       <= 1'b1;
               r_rd_active <= 1'b1;
            end else begin
               r_rd_err    <= 1'b1;
            end
         end else if (w_rd_rise) begin
            r_dout      <= 8'h00;
            r_doe       <= 1'b0;
            r_rd_active <= 1'b0;
         end
      end
   end

   assign data_out        = r_dout;
   assign data_out_enable = r_doe;
   assign rxf_n           = r_rxf_n;
   assign rd_err          = r_rd_err;
   assign rx_count        = r_count;

   // ---------------- Write handshake ----------------
   logic          r_wr_prev, r_txe_n, r_wr_err;
   logic [7:0]    r_wr_data;
   logic [BW-1:0] r_busy;
   logic          w_wr_rise, w_accept;

   assign w_wr_rise = ~r_wr_prev & wr_n;
   assign w_accept  = w_wr_rise & ~r_txe_n;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_prev <= 1'b1;
         r_wr_data <= 8'h00;
         r_txe_n   <= 1'b0;
         r_busy    <= '0;
         r_wr_err  <= 1'b0;
      end else begin
         r_wr_prev <= wr_n;
         r_wr_err  <= 1'b0;
         if (!wr_n) r_wr_data <= data_in;
         if (w_accept) begin
            r_busy  <= BW'(TXE_BUSY_CYCLES);
            r_txe_n <= 1'b1;
         end else begin
            // A rejected write leaves the busy countdown untouched.
            if (w_wr_rise) r_wr_err <= 1'b1;
            if (r_busy > BW'(1)) begin
               r_busy <= r_busy - BW'(1);
            end else if (r_busy == BW'(1)) begin
               r_busy  <= '0;
               r_txe_n <= 1'b0;
            end
         end
      end
   end

   assign txe_n  = r_txe_n;
   assign wr_err = r_wr_err;

   // ---------------- Frame decoder ----------------
   state_t        r_state, w_state_next;
   logic [11:0]   r_nib, w_nib_next;
   logic [15:0]   r_panel;
   logic          r_panel_vld, r_ferr, w_load, w_ferr;
   logic [3:0]    w_tag, w_exp_tag;

   assign w_tag     = r_wr_data[7:4];
   assign w_exp_tag = {2'b00, r_state} + 4'd1;

   always_comb begin
      w_state_next = r_state;
      w_nib_next   = r_nib;
      w_load       = 1'b0;
      w_ferr       = 1'b0;
      if (w_accept) begin
         if (w_tag == w_exp_tag) begin
            case (r_state)
               EXP1: begin w_nib_next[3:0]  = r_wr_data[3:0]; w_state_next = EXP2; end
               EXP2: begin w_nib_next[7:4]  = r_wr_data[3:0]; w_state_next = EXP3; end
               EXP3: begin w_nib_next[11:8] = r_wr_data[3:0]; w_state_next = EXP4; end
               default: begin w_load = 1'b1; w_state_next = EXP1; end
            endcase
         end else begin
            w_ferr = 1'b1;
            // A stray 0x1n tag starts a fresh frame rather than being lost.
            if (w_tag == 4'd1) begin
               w_nib_next[3:0] = r_wr_data[3:0];
               w_state_next    = EXP2;
            end else begin
               w_state_next    = EXP1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= EXP1;
         r_nib       <= '0;
         r_panel     <= 16'h0000;
         r_panel_vld <= 1'b0;
         r_ferr      <= 1'b0;
      end else begin
         r_state     <= w_state_next;
         r_nib       <= w_nib_next;
         r_panel_vld <= w_load;
         r_ferr      <= w_ferr;
         if (w_load) r_panel <= {r_wr_data[3:0], r_nib};
      end
   end

   assign panel_value = r_panel;
   assign panel_valid = r_panel_vld;
   assign frame_error = r_ferr;

endmodule

// File: tb/tb_usb_fifo_responder.sv
// Scoreboard bench for usb_fifo_responder: stimulus queues expected read bytes and panel
// values; a negedge monitor compares them as the DUT presents them.
module tb_usb_fifo_responder;
   localparam int RX_DEPTH = 8;
   localparam int TXE_BUSY = 2;

   logic        clk = 1'b0;
   logic        reset, host_valid, host_ready, rd_n, wr_n;
   logic [7:0]  host_data, data_in, data_out;
   logic        data_out_enable, rxf_n, txe_n, panel_valid, frame_error, rd_err, wr_err;
   logic [15:0] panel_value;
   logic [3:0]  rx_count;

   usb_fifo_responder #(.RX_DEPTH(RX_DEPTH), .TXE_BUSY_CYCLES(TXE_BUSY)) dut (
      .clk(clk), .reset(reset), .host_data(host_data), .host_valid(host_valid),
      .host_ready(host_ready), .rd_n(rd_n), .wr_n(wr_n), .data_in(data_in),
      .data_out(data_out), .data_out_enable(data_out_enable), .rxf_n(rxf_n),
      .txe_n(txe_n), .panel_value(panel_value), .panel_valid(panel_valid),
      .frame_error(frame_error), .rd_err(rd_err), .wr_err(wr_err), .rx_count(rx_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0, n_errors = 0;
   logic [7:0]  model_q[$];
   logic [7:0]  exp_rd[$];
   logic [15:0] exp_panel[$];
   int exp_ferr = 0, exp_rderr = 0, exp_wrerr = 0;
   int got_ferr = 0, got_rderr = 0, got_wrerr = 0;
   logic doe_prev = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: consumes scoreboard entries whenever the DUT presents read data or a panel value.
   always @(negedge clk) begin
      if (data_out_enable && !doe_prev) begin
         if (exp_rd.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL rd_data: unexpected read data %0h", data_out);
         end else check("rd_data", {24'h0, data_out}, {24'h0, exp_rd.pop_front()});
      end
      doe_prev = data_out_enable;
      if (panel_valid) begin
         if (exp_panel.size() == 0) begin
            n_checks++; n_errors++;
            $display("FAIL panel: unexpected panel_valid value %0h", panel_value);
         end else check("panel", {16'h0, panel_value}, {16'h0, exp_panel.pop_front()});
      end
      if (frame_error) got_ferr++;
      if (rd_err)      got_rderr++;
      if (wr_err)      got_wrerr++;
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic push_byte(input logic [7:0] b);
      host_data = b; host_valid = 1'b1;
      if (model_q.size() < RX_DEPTH) model_q.push_back(b);
      tick();
      host_valid = 1'b0;
   endtask

   // Read strobe held low for 'hold' cycles; optionally pushes pb on the rising-edge cycle.
   task automatic do_read(input int hold, input logic [7:0] pb, input bit with_push);
      bit         nonempty;
      logic [7:0] e;
      nonempty = (model_q.size() > 0);
      e = 8'h00;
      if (nonempty) begin e = model_q.pop_front(); exp_rd.push_back(e); end
      else exp_rderr++;
      rd_n = 1'b0;
      repeat (hold) tick();
      check("rd_doe", {31'h0, data_out_enable}, {31'h0, nonempty});
      check("rd_hold", {24'h0, data_out}, {24'h0, e});
      rd_n = 1'b1;
      if (with_push) begin host_data = pb; host_valid = 1'b1; model_q.push_back(pb); end
      tick();
      host_valid = 1'b0;
      check("rd_gap_rxf", {31'h0, rxf_n}, 32'h1);
      check("rd_count", {28'h0, rx_count}, model_q.size());
      check("rd_dout_clr", {23'h0, data_out_enable, data_out}, 32'h0);
   endtask

   task automatic write_byte(input logic [7:0] b, input bit chk_txe);
      int n = 0;
      while (txe_n && n < 20) begin tick(); n++; end
      check("txe_wait", {31'h0, txe_n}, 32'h0);
      wr_n = 1'b0; data_in = b;
      tick();
      wr_n = 1'b1; data_in = 8'hFF;
      tick();
      if (chk_txe) begin
         check("txe_busy1", {31'h0, txe_n}, 32'h1);
         tick();
         check("txe_busy2", {31'h0, txe_n}, 32'h1);
         tick();
         check("txe_free", {31'h0, txe_n}, 32'h0);
      end
   endtask

   // Strobe issued with no txe_n wait; the caller guarantees txe_n is high.
   task automatic bad_write(input logic [7:0] b);
      exp_wrerr++;
      wr_n = 1'b0; data_in = b;
      tick();
      wr_n = 1'b1; data_in = 8'h00;
      tick();
      check("txe_not_extended", {31'h0, txe_n}, 32'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1'b1; host_valid = 1'b0; host_data = 8'h00;
      rd_n = 1'b1; wr_n = 1'b1; data_in = 8'h00;
      tick(); tick();
      check("rst_count", {28'h0, rx_count}, 32'h0);
      check("rst_flags", {28'h0, host_ready, rxf_n, txe_n, data_out_enable}, 32'b1100);
      check("rst_dout", {24'h0, data_out}, 32'h0);
      check("rst_panel", {16'h0, panel_value}, 32'h0);
      check("rst_pulses", {28'h0, panel_valid, frame_error, rd_err, wr_err}, 32'h0);
      reset = 1'b0;
      tick();

      // Basic push / read
      push_byte(8'hA5);
      check("rxf_after_push", {31'h0, rxf_n}, 32'h0);
      push_byte(8'h3C);
      check("count_two", {28'h0, rx_count}, 32'h2);
      do_read(3, 8'h00, 1'b0);
      tick();
      check("rxf_gap_end", {31'h0, rxf_n}, 32'h0);
      do_read(1, 8'h00, 1'b0);
      tick();
      check("rxf_empty", {31'h0, rxf_n}, 32'h1);

      // Fill, overflow attempt, simultaneous push/pop across the wrap, drain
      for (int i = 0; i < RX_DEPTH; i++) push_byte(8'h80 + 8'(i));
      check("full_count", {28'h0, rx_count}, RX_DEPTH);
      check("full_ready", {31'h0, host_ready}, 32'h0);
      push_byte(8'hEE);
      check("full_ignore", {28'h0, rx_count}, RX_DEPTH);
      do_read(1, 8'h00, 1'b0);
      for (int i = 0; i < 4; i++) do_read(1, 8'h90 + 8'(i), 1'b1);
      while (model_q.size() > 0) do_read(1, 8'h00, 1'b0);

      // Read while empty
      do_read(1, 8'h00, 1'b0);
      tick();

      // Good frame
      write_byte(8'h15, 1); write_byte(8'h2A, 1); write_byte(8'h33, 1);
      exp_panel.push_back(16'hC3A5);
      write_byte(8'h4C, 1);

      // Tag violation, then a clean frame
      write_byte(8'h17, 1);
      exp_ferr++;
      write_byte(8'h35, 1);
      write_byte(8'h19, 1); write_byte(8'h21, 1); write_byte(8'h32, 1);
      exp_panel.push_back(16'h3219);
      write_byte(8'h43, 1);

      // 0x1n arriving in EXP3 restarts the frame
      write_byte(8'h11, 1); write_byte(8'h22, 1);
      exp_ferr++;
      write_byte(8'h14, 1);
      write_byte(8'h25, 1); write_byte(8'h36, 1);
      exp_panel.push_back(16'h7654);
      write_byte(8'h47, 1);

      // Write while busy is dropped
      write_byte(8'h15, 0);
      bad_write(8'h2A);
      write_byte(8'h2B, 1); write_byte(8'h3C, 1);
      exp_panel.push_back(16'hDCB5);
      write_byte(8'h4D, 1);

      // Reset in the middle of a frame
      write_byte(8'h11, 1); write_byte(8'h22, 1);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrst_panel", {16'h0, panel_value}, 32'h0);
      check("midrst_txe", {31'h0, txe_n}, 32'h0);
      write_byte(8'h15, 1); write_byte(8'h26, 1); write_byte(8'h37, 1);
      exp_panel.push_back(16'h8765);
      write_byte(8'h48, 1);

      repeat (4) tick();
      check("rd_q_drained", exp_rd.size(), 32'h0);
      check("panel_q_drained", exp_panel.size(), 32'h0);
      check("frame_err_pulses", got_ferr, exp_ferr);
      check("rd_err_pulses", got_rderr, exp_rderr);
      check("wr_err_pulses", got_wrerr, exp_wrerr);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule
